// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: word widths, halt encoding, fetch FSM states.
// Imported by fetch_unit and fetch_fifo.
package cpu_pkg;
  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 16'hFFFF;

  typedef enum logic [1:0] {
    RUN,
    HALT_WAIT,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc,instr} entries with synchronous push/pop and flush.
// DEPTH must be a power of two so the pointers wrap for free.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: imem driver, prefetch FIFO, redirect and halt.
// Define FETCH_PERF_EN to add perf_fetched/perf_stall counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              inflight_q;
  logic              req_epoch_q;
  logic              epoch_q;
  logic              halted_q;
  fetch_entry_t      last_q;
  fetch_entry_t      head;
  fetch_entry_t      resp;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       used;
  logic              resp_ok;
  logic              handshake;

  // Credit covers the in-flight word so a response always has a slot.
  assign used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign imem_req = !rst && (state_q == RUN) && !redirect_valid
                    && (used < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign resp_ok = inflight_q && (req_epoch_q == epoch_q)
                   && (state_q == RUN) && !redirect_valid;
  assign resp = '{pc: req_pc_q, instr: imem_rdata};

  assign instr_valid = (fifo_count != '0);
  assign handshake   = instr_valid && instr_ready;
  assign instr_out   = instr_valid ? head.instr : last_q.instr;
  assign instr_pc    = instr_valid ? head.pc : last_q.pc;
  assign halted      = halted_q;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (resp_ok),
    .push_data (resp),
    .pop       (handshake),
    .head      (head),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      inflight_q  <= 1'b0;
      req_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
      halted_q    <= 1'b0;
      last_q      <= '0;
    end else begin
      if (handshake) last_q <= head;
      inflight_q <= imem_req;
      if (imem_req) begin
        req_pc_q    <= fetch_pc_q;
        req_epoch_q <= epoch_q;
        fetch_pc_q  <= fetch_pc_q + ADDR_W'(1);
      end
      if (redirect_valid) begin
        epoch_q    <= ~epoch_q;
        fetch_pc_q <= redirect_pc;
        state_q    <= RUN;
        halted_q   <= 1'b0;
      end else begin
        unique case (state_q)
          RUN: begin
            if (resp_ok && imem_rdata == HALT_INSTR)
              state_q <= HALT_WAIT;
          end
          HALT_WAIT: begin
            if (handshake && fifo_count == CW'(1)) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (handshake && perf_fetched != 16'hFFFF)
        perf_fetched <= perf_fetched + 16'd1;
      if (instr_ready && !instr_valid && state_q != HALTED
          && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule
